// File: rtl/light_pkg.sv
// Shared definitions for the traffic-light sequence checker.
//   light_e      : phase encoding as reported on the phase output
//   LAMP_*       : one-hot lamp codes seen on lights ([2]=red, [1]=yellow, [0]=green)
//   err_code_e   : error codes reported on err_code
//   next_phase() : legal successor phase (RED -> GREEN -> YELLOW -> RED)
//   lamp_legal() / lamp_to_phase() : decode helpers for raw lamp samples
package light_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } light_e;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_ILLEGAL     = 3'd1,
        ERR_BAD_ORDER   = 3'd2,
        ERR_SHORT_DWELL = 3'd3,
        ERR_TIMEOUT     = 3'd4
    } err_code_e;

    function automatic light_e next_phase(input light_e p);
        case (p)
            RED:     next_phase = GREEN;
            GREEN:   next_phase = YELLOW;
            default: next_phase = RED;
        endcase
    endfunction

    function automatic logic lamp_legal(input logic [2:0] l);
        lamp_legal = (l == LAMP_RED) || (l == LAMP_GREEN) || (l == LAMP_YELLOW);
    endfunction

    // Only meaningful for legal codes; anything else maps to RED.
    function automatic light_e lamp_to_phase(input logic [2:0] l);
        case (l)
            LAMP_GREEN:  lamp_to_phase = GREEN;
            LAMP_YELLOW: lamp_to_phase = YELLOW;
            default:     lamp_to_phase = RED;
        endcase
    endfunction

endpackage

// File: rtl/light_dwell_counter.sv
// Saturating dwell counter for the sequence checker.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (count -> 0)
//   clear_to_one  : load 1 (first sample of a new phase); wins over inc
//   inc           : count up, saturating at MAX_DWELL
//   count         : current dwell value
//   at_max        : the next increment lands on (or stays at) MAX_DWELL
module light_dwell_counter #(
    parameter int MAX_DWELL = 60,
    parameter int W         = $clog2(MAX_DWELL + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_to_one,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] CNT_MAX = W'(MAX_DWELL);

    // Flagging one step early lets the owner raise the timeout on the very
    // edge at which dwell reaches MAX_DWELL, without an extra cycle of latency.
    assign at_max = (count >= CNT_MAX - W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear_to_one) begin
            count <= W'(1);
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/light_sequence_checker.sv
// Checks the lamp sequence of the traffic-light controller.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   lights       : observed lamps [2]=red [1]=yellow [0]=green
//   phase_valid  : locked to the sequence
//   phase        : current phase (0=RED 1=GREEN 2=YELLOW), valid with phase_valid
//   err_valid    : one-cycle error strobe
//   err_code     : 1=ILLEGAL 2=BAD_ORDER 3=SHORT_DWELL 4=TIMEOUT
//   err_count    : total errors, saturating at 255
//   cycles_done  : completed red->green->yellow->red rounds while locked (wraps)
//
// state  | meaning
// -------+---------------------------------------------------------------
// SYNC   | not locked; waiting for a legal successor transition
// LOCKED | following the sequence; dwell and order are checked
module light_sequence_checker
    import light_pkg::*;
#(
    parameter int RED_MIN    = 10,
    parameter int GREEN_MIN  = 10,
    parameter int YELLOW_MIN = 3,
    parameter int MAX_DWELL  = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  lights,
    output logic        phase_valid,
    output logic [1:0]  phase,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic [7:0]  err_count,
    output logic [15:0] cycles_done
);

    localparam int DW = $clog2(MAX_DWELL + 1);

    localparam logic ST_SYNC   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic          state, state_nxt;
    logic [2:0]    prev, prev_nxt;
    logic [DW-1:0] dwell;
    logic          dwell_at_max;
    logic          dwell_clr, dwell_inc;
    logic          err, round_done;
    err_code_e     code;

    logic          cur_legal, prev_legal, changed, is_succ;
    light_e        cur_ph, prev_ph;
    logic [DW-1:0] min_for_prev;

    assign cur_legal  = lamp_legal(lights);
    assign prev_legal = lamp_legal(prev);
    assign cur_ph     = lamp_to_phase(lights);
    assign prev_ph    = lamp_to_phase(prev);
    assign changed    = (lights != prev);
    assign is_succ    = cur_legal && prev_legal && (cur_ph == next_phase(prev_ph));

    always_comb begin
        case (prev_ph)
            GREEN:   min_for_prev = DW'(GREEN_MIN);
            YELLOW:  min_for_prev = DW'(YELLOW_MIN);
            default: min_for_prev = DW'(RED_MIN);
        endcase
    end

    light_dwell_counter #(
        .MAX_DWELL (MAX_DWELL),
        .W         (DW)
    ) u_dwell (
        .clk          (clk),
        .rst          (rst),
        .clear_to_one (dwell_clr),
        .inc          (dwell_inc),
        .count        (dwell),
        .at_max       (dwell_at_max)
    );

    always_comb begin
        state_nxt  = state;
        prev_nxt   = prev;
        err        = 1'b0;
        code       = ERR_NONE;
        dwell_clr  = 1'b0;
        dwell_inc  = 1'b0;
        round_done = 1'b0;

        if (state == ST_SYNC) begin
            // First phase is only partially observed, so no dwell checks here.
            if (!cur_legal) begin
                err      = 1'b1;
                code     = ERR_ILLEGAL;
                prev_nxt = lights;
            end else if (changed) begin
                prev_nxt = lights;
                if (is_succ) begin
                    state_nxt = ST_LOCKED;
                    dwell_clr = 1'b1;
                end
            end
        end else begin
            if (!changed) begin
                dwell_inc = 1'b1;
                if (dwell_at_max) begin
                    err  = 1'b1;
                    code = ERR_TIMEOUT;
                end
            end else begin
                prev_nxt = lights;
                if (!cur_legal) begin
                    err  = 1'b1;
                    code = ERR_ILLEGAL;
                end else if (!is_succ) begin
                    err  = 1'b1;
                    code = ERR_BAD_ORDER;
                end else if (dwell < min_for_prev) begin
                    err  = 1'b1;
                    code = ERR_SHORT_DWELL;
                end else begin
                    dwell_clr  = 1'b1;
                    round_done = (prev_ph == YELLOW);
                end
            end
        end

        if (err) begin
            state_nxt = ST_SYNC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SYNC;
            prev        <= 3'b000;
            phase_valid <= 1'b0;
            phase       <= 2'd0;
            err_valid   <= 1'b0;
            err_code    <= 3'd0;
            err_count   <= 8'd0;
            cycles_done <= 16'd0;
        end else begin
            state       <= state_nxt;
            prev        <= prev_nxt;
            phase_valid <= (state_nxt == ST_LOCKED);
            if (state_nxt == ST_LOCKED) begin
                phase <= cur_ph;
            end
            err_valid <= err;
            err_code  <= code;
            if (err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (round_done) begin
                cycles_done <= cycles_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_light_sequence_checker.sv
module tb_light_sequence_checker;
    import light_pkg::*;

    typedef struct {
        string       tag;
        logic        pv;
        logic [1:0]  ph;
        logic        ev;
        logic [2:0]  ec;
        logic [7:0]  cnt;
        logic [15:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  lights;
    logic        phase_valid;
    logic [1:0]  phase;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [7:0]  err_count;
    logic [15:0] cycles_done;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    light_sequence_checker dut (
        .clk         (clk),
        .rst         (rst),
        .lights      (lights),
        .phase_valid (phase_valid),
        .phase       (phase),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .err_count   (err_count),
        .cycles_done (cycles_done)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired, observed no end of stimulus, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty observed 0 entries required 1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (phase_valid === e.pv) else begin
            errors++;
            $error("FAIL %s phase_valid observed %0b expected %0b", e.tag, phase_valid, e.pv);
        end
        if (e.pv) begin
            checks++;
            assert (phase === e.ph) else begin
                errors++;
                $error("FAIL %s phase observed %0d expected %0d", e.tag, phase, e.ph);
            end
        end
        checks++;
        assert (err_valid === e.ev) else begin
            errors++;
            $error("FAIL %s err_valid observed %0b expected %0b", e.tag, err_valid, e.ev);
        end
        if (e.ev) begin
            checks++;
            assert (err_code === e.ec) else begin
                errors++;
                $error("FAIL %s err_code observed %0d expected %0d", e.tag, err_code, e.ec);
            end
        end
        checks++;
        assert (err_count === e.cnt) else begin
            errors++;
            $error("FAIL %s err_count observed %0d expected %0d", e.tag, err_count, e.cnt);
        end
        checks++;
        assert (cycles_done === e.cyc) else begin
            errors++;
            $error("FAIL %s cycles_done observed %0d expected %0d", e.tag, cycles_done, e.cyc);
        end
    endtask

    // Drive one sample with rst level r, then compare after the sampling edge.
    task automatic step(input string tag, input logic [2:0] l, input logic r,
                        input logic pv, input logic [1:0] ph, input logic ev,
                        input logic [2:0] ec, input logic [7:0] cnt, input logic [15:0] cyc);
        exp_t e;
        e.tag = tag; e.pv = pv; e.ph = ph; e.ev = ev; e.ec = ec; e.cnt = cnt; e.cyc = cyc;
        @(negedge clk);
        lights = l;
        rst    = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run(input string tag, input logic [2:0] l, input int n,
                       input logic pv, input logic [1:0] ph, input logic ev,
                       input logic [2:0] ec, input logic [7:0] cnt, input logic [15:0] cyc);
        for (int i = 0; i < n; i++) step(tag, l, 1'b0, pv, ph, ev, ec, cnt, cyc);
    endtask

    task automatic do_reset();
        step("reset", 3'b000, 1'b1, 0, 0, 0, 0, 0, 0);
        step("reset", 3'b000, 1'b1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst    = 1'b1;
        lights = 3'b000;

        // Clean round
        do_reset();
        run("clean_red",    LAMP_RED,    15, 0, 0, 0, 0, 0, 0);
        run("clean_green",  LAMP_GREEN,  12, 1, 1, 0, 0, 0, 0);
        run("clean_yellow", LAMP_YELLOW,  3, 1, 2, 0, 0, 0, 0);
        run("clean_red2",   LAMP_RED,     1, 1, 0, 0, 0, 0, 1);

        // Short dwell in green
        run("short_red",    LAMP_RED,     9, 1, 0, 0, 0, 0, 1);
        run("short_green",  LAMP_GREEN,   5, 1, 1, 0, 0, 0, 1);
        run("short_err",    LAMP_YELLOW,  1, 0, 0, 1, 3, 1, 1);
        run("short_after",  LAMP_YELLOW,  2, 0, 0, 0, 0, 1, 1);

        // Illegal value while locked, held three cycles
        do_reset();
        run("ill_red",      LAMP_RED,     2, 0, 0, 0, 0, 0, 0);
        run("ill_green",    LAMP_GREEN,   1, 1, 1, 0, 0, 0, 0);
        run("ill_1",        3'b110,       1, 0, 0, 1, 1, 1, 0);
        run("ill_2",        3'b110,       1, 0, 0, 1, 1, 2, 0);
        run("ill_3",        3'b110,       1, 0, 0, 1, 1, 3, 0);

        // Bad order: locked red then yellow; relock needs a successor transition
        do_reset();
        run("bo_red",       LAMP_RED,     1, 0, 0, 0, 0, 0, 0);
        run("bo_green",     LAMP_GREEN,  10, 1, 1, 0, 0, 0, 0);
        run("bo_yellow",    LAMP_YELLOW,  3, 1, 2, 0, 0, 0, 0);
        run("bo_red_lock",  LAMP_RED,     3, 1, 0, 0, 0, 0, 1);
        run("bo_err",       LAMP_YELLOW,  1, 0, 0, 1, 2, 1, 1);
        run("bo_hold",      LAMP_YELLOW,  1, 0, 0, 0, 0, 1, 1);
        run("bo_nolock",    LAMP_GREEN,   2, 0, 0, 0, 0, 1, 1);
        run("bo_relock",    LAMP_YELLOW,  1, 1, 2, 0, 0, 1, 1);

        // Timeout on a stuck red
        do_reset();
        run("to_red",       LAMP_RED,     1, 0, 0, 0, 0, 0, 0);
        run("to_green",     LAMP_GREEN,  10, 1, 1, 0, 0, 0, 0);
        run("to_yellow",    LAMP_YELLOW,  3, 1, 2, 0, 0, 0, 0);
        run("to_red_lock",  LAMP_RED,    59, 1, 0, 0, 0, 0, 1);
        run("to_err",       LAMP_RED,     1, 0, 0, 1, 4, 1, 1);
        run("to_quiet",     LAMP_RED,     5, 0, 0, 0, 0, 1, 1);

        // Reset mid-green
        do_reset();
        run("rm_red",       LAMP_RED,     1, 0, 0, 0, 0, 0, 0);
        run("rm_green",     LAMP_GREEN,   3, 1, 1, 0, 0, 0, 0);
        step("rm_rst",      LAMP_GREEN, 1'b1, 0, 0, 0, 0, 0, 0);
        run("rm_after",     LAMP_GREEN,   2, 0, 0, 0, 0, 0, 0);

        // Error counter saturation
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            step("sat", 3'b000, 1'b0, 0, 0, 1, 1, (k > 255) ? 8'd255 : 8'(k), 0);
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
